// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - opcode/state types and compare helpers for the ula command sequencer
package ula_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_NAND = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOR  = 4'd7,
        OP_EQ   = 4'd8,
        OP_GTE  = 4'd9,
        OP_LTE  = 4'd10
    } ula_op_e;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } seq_state_e;

    localparam logic [3:0] OP_LAST = 4'd10;

    function automatic logic is_compare(input logic [3:0] op);
        return (op == OP_EQ) || (op == OP_GTE) || (op == OP_LTE);
    endfunction

    // Compares run as a - b on the ula; the boolean comes from the flags of that subtraction.
    function automatic logic [15:0] cmp_result(input logic [3:0] op, input logic zero,
                                               input logic sign);
        logic bit_val;
        case (op)
            OP_EQ:   bit_val = zero;
            OP_GTE:  bit_val = !sign;
            OP_LTE:  bit_val = sign | zero;
            default: bit_val = 1'b0;
        endcase
        return {15'b0, bit_val};
    endfunction

endpackage

// File: rtl/ula_op_sequencer.sv
// rtl/ula_op_sequencer.sv - drives the combinational ula with one command at a time and returns its result
module ula_op_sequencer
    import ula_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_sel,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_sign,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_sign,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] ops_done
);

    seq_state_e state, state_next;
    logic [3:0] settle_cnt;
    logic [3:0] op_q;
    logic       illegal;

    assign illegal   = cmd_op > OP_LAST;
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = DRIVE;
            DRIVE:   if (settle_cnt == 4'd0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Illegal ops pass through DRIVE with a zero count so the response still lands one cycle
    // after accept, but the ula is neither driven nor sampled for them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
            alu_sel    <= 4'd0;
            settle_cnt <= 4'd0;
            op_q       <= 4'd0;
            rsp_result <= 16'd0;
            rsp_zero   <= 1'b0;
            rsp_sign   <= 1'b0;
            rsp_err    <= 1'b0;
            ops_done   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q <= cmd_op;
                        if (illegal) begin
                            settle_cnt <= 4'd0;
                            rsp_err    <= 1'b1;
                            rsp_result <= 16'd0;
                            rsp_zero   <= 1'b0;
                            rsp_sign   <= 1'b0;
                        end else begin
                            alu_a      <= cmd_a;
                            alu_b      <= cmd_b;
                            alu_sel    <= is_compare(cmd_op) ? OP_SUB : cmd_op;
                            settle_cnt <= 4'(SETTLE_CYCLES - 1);
                            rsp_err    <= 1'b0;
                        end
                    end
                end
                DRIVE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else if (op_q <= OP_LAST) begin
                        rsp_zero   <= alu_zero;
                        rsp_sign   <= alu_sign;
                        rsp_result <= is_compare(op_q) ? cmp_result(op_q, alu_zero, alu_sign)
                                                       : alu_result;
                    end
                end
                RESP: begin
                    if (rsp_ready) ops_done <= ops_done + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_op_sequencer.sv
// tb/tb_ula_op_sequencer.sv - directed bench for ula_op_sequencer with a behavioural ula beside it
module tb_ula_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [17:0] ula(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] sel);
        logic [15:0] r;
        case (sel)
            4'd0:    r = {8'd0, a} + {8'd0, b};
            4'd1:    r = {8'd0, a} - {8'd0, b};
            4'd2:    r = a * b;
            4'd3:    r = {8'd0, a & b};
            4'd4:    r = {8'd0, a | b};
            4'd5:    r = {8'd0, ~(a & b)};
            4'd6:    r = {8'd0, a ^ b};
            4'd7:    r = {8'd0, ~(a | b)};
            default: r = 16'd0;
        endcase
        return {r[15], (r == 16'd0), r};
    endfunction

    logic        rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [3:0]  cmd_op, alu_sel;
    logic [7:0]  cmd_a, cmd_b, alu_a, alu_b;
    logic [15:0] alu_result, rsp_result, ops_done;
    logic        alu_zero, alu_sign, rsp_zero, rsp_sign, rsp_err, busy;

    assign {alu_sign, alu_zero, alu_result} = ula(alu_a, alu_b, alu_sel);

    ula_op_sequencer #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_err(rsp_err),
        .busy(busy), .ops_done(ops_done)
    );

    logic        rst_n3, cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3;
    logic [3:0]  cmd_op3, alu_sel3;
    logic [7:0]  cmd_a3, cmd_b3, alu_a3, alu_b3;
    logic [15:0] alu_result3, rsp_result3, ops_done3;
    logic        alu_zero3, alu_sign3, rsp_zero3, rsp_sign3, rsp_err3, busy3;

    assign {alu_sign3, alu_zero3, alu_result3} = ula(alu_a3, alu_b3, alu_sel3);

    ula_op_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n3), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_op(cmd_op3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
        .alu_result(alu_result3), .alu_zero(alu_zero3), .alu_sign(alu_sign3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
        .rsp_zero(rsp_zero3), .rsp_sign(rsp_sign3), .rsp_err(rsp_err3),
        .busy(busy3), .ops_done(ops_done3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send1(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait1(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack1;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("ack_idle", {cmd_ready, rsp_valid, busy}, 3'b100);
    endtask

    task automatic run1(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp_res, input logic exp_zero,
                        input logic exp_err);
        int lat;
        send1(op, a, b);
        wait1(lat);
        check({tag, "_lat"}, 64'(lat), 64'd1);
        check({tag, "_rsp"}, {rsp_result, rsp_zero, rsp_err}, {exp_res, exp_zero, exp_err});
        ack1();
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 8'd0; cmd_b = 8'd0;
        rsp_ready = 1'b0;
        rst_n3 = 1'b0; cmd_valid3 = 1'b0; cmd_op3 = 4'd0; cmd_a3 = 8'd0; cmd_b3 = 8'd0;
        rsp_ready3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {cmd_ready, rsp_valid, busy, alu_a, alu_b, alu_sel, rsp_result,
                              rsp_zero, rsp_sign, rsp_err, ops_done},
              {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 16'd0, 3'b000, 16'd0});
        @(negedge clk);
        rst_n = 1'b1; rst_n3 = 1'b1;

        run1("add", 4'd0, 8'd200, 8'd100, 16'd300, 1'b0, 1'b0);
        check("ops_done_1", ops_done, 16'd1);
        run1("mul", 4'd2, 8'd12, 8'd10, 16'd120, 1'b0, 1'b0);
        run1("xor", 4'd6, 8'hF0, 8'hF0, 16'd0, 1'b1, 1'b0);

        send1(4'd8, 8'd5, 8'd5);
        check("eq_sel", alu_sel, 4'd1);
        wait1(lat);
        check("eq_rsp", {rsp_result, rsp_zero, rsp_sign}, {16'd1, 1'b1, 1'b0});
        ack1();
        send1(4'd9, 8'd3, 8'd7);
        check("gte_sel", alu_sel, 4'd1);
        wait1(lat);
        check("gte_rsp", {rsp_result, rsp_zero, rsp_sign}, {16'd0, 1'b0, 1'b1});
        ack1();
        send1(4'd10, 8'd3, 8'd7);
        check("lte_sel", alu_sel, 4'd1);
        wait1(lat);
        check("lte_rsp", {rsp_result, rsp_zero, rsp_sign}, {16'd1, 1'b0, 1'b1});
        ack1();

        send1(4'hC, 8'd99, 8'd77);
        wait1(lat);
        check("ill_lat", 64'(lat), 64'd1);
        check("ill_rsp", {rsp_result, rsp_zero, rsp_sign, rsp_err}, {16'd0, 3'b001});
        check("ill_alu", {alu_a, alu_b, alu_sel}, {8'd3, 8'd7, 4'd1});
        ack1();
        run1("after_ill", 4'd1, 8'd9, 8'd4, 16'd5, 1'b0, 1'b0);
        check("ops_done_8", ops_done, 16'd8);

        send1(4'd4, 8'h0F, 8'h30);
        wait1(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold", {rsp_valid, cmd_ready, busy, rsp_result, rsp_err},
                  {3'b101, 16'h003F, 1'b0});
        end
        ack1();
        check("ops_done_9", ops_done, 16'd9);

        @(negedge clk);
        cmd_valid3 = 1'b1; cmd_op3 = 4'd0; cmd_a3 = 8'd9; cmd_b3 = 8'd4;
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        lat = 0;
        while (!rsp_valid3 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("s3_lat", 64'(lat), 64'd3);
        check("s3_rsp", rsp_result3, 16'd13);
        @(negedge clk);
        rsp_ready3 = 1'b1;
        @(posedge clk); #1;
        rsp_ready3 = 1'b0;
        check("s3_ops", ops_done3, 16'd1);

        @(negedge clk);
        cmd_valid3 = 1'b1; cmd_op3 = 4'd2; cmd_a3 = 8'd6; cmd_b3 = 8'd7;
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        @(posedge clk); #1;
        check("s3_mid_drive", {busy3, alu_a3}, {1'b1, 8'd6});
        #2;
        rst_n3 = 1'b0;
        #1;
        check("s3_reset", {cmd_ready3, rsp_valid3, busy3, alu_a3, alu_b3, alu_sel3,
                           rsp_result3, rsp_zero3, rsp_sign3, rsp_err3, ops_done3},
              {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0, 16'd0, 3'b000, 16'd0});
        @(negedge clk);
        rst_n3 = 1'b1;
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid3 || busy3) lat++;
        end
        check("s3_no_stray", 64'(lat), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
